// File: rtl/sigmoid_if.sv
// Sample bundle for the sigmoid unit.
// Carries the 19-bit float in and the 12-bit float out.
interface sigmoid_if;
  logic        Sign;
  logic [5:0]  Exponent;
  logic [11:0] Mantissa;
  logic        SignOut;
  logic [4:0]  ExponentOut;
  logic [5:0]  MantissaOut;

  modport master (
    output Sign, Exponent, Mantissa,
    input  SignOut, ExponentOut, MantissaOut
  );

  modport slave (
    input  Sign, Exponent, Mantissa,
    output SignOut, ExponentOut, MantissaOut
  );
endinterface

// File: rtl/sigmoid_unit.sv
// Three-stage PLAN sigmoid: float19 -> Q4.12 -> Q1.16 -> float12.
// Define SIGMOID_ROUND_EN for round-to-nearest in the last stage.
module sigmoid_unit (
  input  logic      Clock,
  input  logic      ResetN,
  sigmoid_if.slave  bus
);

  typedef struct packed {
    logic        vld;
    logic        sgn;
    logic        big;
    logic [15:0] mag;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic [16:0] y;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic [4:0] exp_d, exp_q;
  logic [5:0] man_d, man_q;

  logic signed [6:0] e;
  logic [6:0]        ne;
  logic [12:0]       sig;
  logic              is_zero;
  logic              is_big;
  logic              is_pos;
  logic              is_neg;

  always_comb begin
    e       = $signed({1'b0, bus.Exponent}) - 7'sd31;
    ne      = 7'(-e);
    sig     = {1'b1, bus.Mantissa};
    is_zero = (bus.Exponent == 6'd0)
            || (e < -7'sd12);
    is_big  = (e >= 7'sd3);
    is_pos  = (e >= 7'sd0) && (e < 7'sd3);
    is_neg  = (e < 7'sd0) && (e >= -7'sd12)
            && (bus.Exponent != 6'd0);
    s1_d     = '0;
    s1_d.vld = 1'b1;
    s1_d.sgn = bus.Sign;
    unique case (1'b1)
      is_zero: s1_d.mag = '0;
      is_big:  s1_d.big = 1'b1;
      is_pos:  s1_d.mag = 16'(sig) << e[1:0];
      is_neg:  s1_d.mag = 16'(sig) >> ne[3:0];
      default: s1_d.mag = '0;
    endcase
  end

  logic [15:0] m;
  logic [16:0] p;
  logic        sat;
  logic        seg_hi;
  logic        seg_mid;
  logic        seg_lo;

  // Segment slopes are powers of two, so each is a plain shift of m.
  always_comb begin
    m       = s1_q.mag;
    sat     = s1_q.big || (m >= 16'd20480);
    seg_hi  = !sat && (m >= 16'd9728);
    seg_mid = !sat && !seg_hi
            && (m >= 16'd4096);
    seg_lo  = !sat && (m < 16'd4096);
    p = '0;
    unique case (1'b1)
      sat:     p = 17'h10000;
      seg_hi:  p = 17'(m >> 1) + 17'd55296;
      seg_mid: p = (17'(m) << 1) + 17'd40960;
      seg_lo:  p = (17'(m) << 2) + 17'd32768;
      default: p = '0;
    endcase
    s2_d.vld = s1_q.vld;
    s2_d.y   = s1_q.sgn
             ? 17'h10000 - p : p;
  end

  logic [4:0]  k;
  logic        nz;
  logic [4:0]  sh;
  logic [16:0] norm;
  logic [4:0]  exp_t;
  logic [5:0]  man_t;
`ifdef SIGMOID_ROUND_EN
  logic [6:0]  man_r;
`endif

  always_comb begin
    k  = '0;
    nz = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (s2_q.y[i]) begin
        k  = 5'(i);
        nz = 1'b1;
      end
    end
    sh    = 5'd16 - k;
    norm  = s2_q.y << sh;
    exp_t = k - 5'd1;
    man_t = norm[15:10];
`ifdef SIGMOID_ROUND_EN
    man_r = {1'b0, man_t} + {6'd0, norm[9]};
    if (man_r[6]) begin
      exp_t = exp_t + 5'd1;
      man_t = '0;
    end else begin
      man_t = man_r[5:0];
    end
    if (exp_t > 5'd15) begin
      exp_t = 5'd15;
      man_t = '0;
    end
`endif
    exp_d = '0;
    man_d = '0;
    // Results below 2^-14 have no encoding; flush them to zero.
    if (s2_q.vld && nz && (k >= 5'd2)) begin
      exp_d = exp_t;
      man_d = man_t;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      s1_q  <= '0;
      s2_q  <= '0;
      exp_q <= '0;
      man_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      exp_q <= exp_d;
      man_q <= man_d;
    end
  end

  assign bus.SignOut     = 1'b0;
  assign bus.ExponentOut = exp_q;
  assign bus.MantissaOut = man_q;

endmodule

// File: tb/tb_sigmoid_unit.sv
// Self-checking bench for sigmoid_unit.
// Directed spec vectors plus a random stream against a reference model.
module tb_sigmoid_unit;

  logic Clock;
  logic ResetN;

  sigmoid_if bus();

  sigmoid_unit dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks;
  int errors;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  // Reference: real-valued rules evaluated with integer arithmetic.
  function automatic logic [10:0] model(
    input bit s, input int ex, input int ma);
    longint v, p, y, r;
    int e, k, eo, mo;
    e = ex - 31;
    if (ex == 0 || e < -12) v = 0;
    else if (e >= 3) v = -1;
    else if (e >= 0) v = (4096 + ma) * (64'd1 << e);
    else v = (4096 + ma) / (64'd1 << (-e));
    if (v < 0 || v >= 20480) p = 65536;
    else if (v >= 9728) p = v / 2 + 55296;
    else if (v >= 4096) p = 2 * v + 40960;
    else p = 4 * v + 32768;
    y = s ? 65536 - p : p;
    if (y < 4) return 11'd0;
    k = 0;
    while ((64'd1 << (k + 1)) <= y) k++;
    r = (y * 128) >> k;
`ifdef SIGMOID_ROUND_EN
    r = (r + 1) >> 1;
`else
    r = r >> 1;
`endif
    eo = k - 1;
    mo = int'(r) - 64;
    if (mo >= 64) begin
      eo++;
      mo = 0;
    end
    if (eo > 15) begin
      eo = 15;
      mo = 0;
    end
    return {eo[4:0], mo[5:0]};
  endfunction

  task automatic cycle(
    input bit s, input logic [5:0] e,
    input logic [11:0] m,
    input logic [10:0] want, input string nm);
    logic [11:0] got, req;
    string tg;
    bus.Sign     = s;
    bus.Exponent = e;
    bus.Mantissa = m;
    exp_q.push_back(want);
    tag_q.push_back(nm);
    @(posedge Clock);
    #1;
    if (exp_q.size() >= 3) begin
      req = {1'b0, exp_q.pop_front()};
      tg  = tag_q.pop_front();
    end else begin
      req = '0;
      tg  = "pipe_fill";
    end
    got = {bus.SignOut, bus.ExponentOut,
           bus.MantissaOut};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got s/e/m %0d/%0d/%b want %0d/%0d/%b",
               tg, got[11], got[10:6], got[5:0],
               req[11], req[10:6], req[5:0]);
    end
  endtask

  task automatic check_zero(input string nm);
    logic [11:0] got;
    got = {bus.SignOut, bus.ExponentOut,
           bus.MantissaOut};
    checks++;
    if (got !== 12'd0) begin
      errors++;
      $display("FAIL %s got %h want 000", nm, got);
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.Sign     = 1'($urandom);
      bus.Exponent = 6'($urandom);
      bus.Mantissa = 12'($urandom);
      @(posedge Clock);
      #1;
      check_zero("reset");
    end
    exp_q.delete();
    tag_q.delete();
    ResetN = 1'b1;
  endtask

  typedef struct {
    bit          s;
    logic [5:0]  e;
    logic [11:0] m;
    logic [10:0] want;
    string       nm;
  } vec_t;

  vec_t vecs[9];

  task automatic load_vecs();
    vecs[0] = '{0, 6'b111001, 12'b001100011111,
                {5'd15, 6'd0}, "big_pos"};
    vecs[1] = '{1, 6'b111001, 12'b001100011111,
                11'd0, "big_neg"};
    vecs[2] = '{0, 6'd0, 12'habc,
                {5'd14, 6'd0}, "zero"};
    vecs[3] = '{0, 6'd31, 12'h000,
                {5'd14, 6'b100000}, "plus_one"};
    vecs[4] = '{1, 6'd31, 12'h000,
                {5'd13, 6'd0}, "minus_one"};
    vecs[5] = '{0, 6'd30, 12'h000,
                {5'd14, 6'b010000}, "plus_half"};
    vecs[6] = '{0, 6'd32, 12'h800,
                {5'd14, 6'b111000}, "plus_three"};
    vecs[7] = '{0, 6'd63, 12'hfff,
                {5'd15, 6'd0}, "exp63_pos"};
    vecs[8] = '{1, 6'd63, 12'hfff,
                11'd0, "exp63_neg"};
  endtask

  task automatic test_vectors();
    foreach (vecs[i]) begin
      cycle(vecs[i].s, vecs[i].e, vecs[i].m,
            vecs[i].want, vecs[i].nm);
      for (int j = 0; j < 2; j++)
        cycle(0, 6'd0, 12'd0, {5'd14, 6'd0}, "gap");
    end
  endtask

  task automatic test_back_to_back();
    foreach (vecs[i])
      cycle(vecs[i].s, vecs[i].e, vecs[i].m,
            vecs[i].want, vecs[i].nm);
  endtask

  task automatic test_random();
    bit s;
    logic [5:0] e;
    logic [11:0] m;
    for (int i = 0; i < 400; i++) begin
      s = 1'($urandom);
      if ($urandom_range(3) != 0)
        e = 6'($urandom_range(36, 17));
      else
        e = 6'($urandom);
      m = 12'($urandom);
      cycle(s, e, m, model(s, int'(e), int'(m)),
            "random");
    end
  endtask

  task automatic test_mid_reset();
    cycle(0, 6'd31, 12'd0, {5'd14, 6'b100000}, "pre_rst");
    cycle(1, 6'd31, 12'd0, {5'd13, 6'd0}, "pre_rst");
    ResetN = 1'b0;
    @(posedge Clock);
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    tag_q.delete();
    ResetN = 1'b1;
    for (int i = 0; i < 6; i++)
      cycle(0, 6'd30, 12'd0, {5'd14, 6'b010000},
            "post_rst");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ResetN = 1'b0;
    bus.Sign = 1'b0;
    bus.Exponent = '0;
    bus.Mantissa = '0;
    load_vecs();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
